vga_fb_arbiter: RTL and testbench

- Shares one single-port synchronous framebuffer RAM between the display pixel fetch and a host (CPU/drawing engine) access port.
- Sits between vga_sync and the framebuffer, in the clk_vga domain.
- Display fetch has absolute priority whenever vga_sync reports visible area. Host accesses are granted only during blanking.
- Generates the linear display read address, resynchronised to each frame by first_pixel.

---
 rtl/vga_fb_arbiter.sv | 171 +++++++++++++++++
 tb/tb_vga_fb_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter
// Shares one single-port synchronous framebuffer RAM between the display
// pixel fetch and a host access port, in the clk_vga domain. Display fetch
// wins whenever vga_video_on is high. Host accesses are issued only during
// blanking. Display latency is fixed at 3 cycles from vga_video_on to
// pixel_valid.
//
// Ports:
//   clk_vga, rst              pixel clock, synchronous active-high reset
//   vga_video_on, first_pixel timing from vga_sync
//   host_req/we/addr/wdata    host request, held until host_ack
//   host_ack, host_rvalid,    host handshake pulses and read data
//   host_rdata
//   mem_re/we/addr/wdata      registered memory command
//   mem_rdata                 memory read data, valid 1 cycle after mem_re
//   pixel_valid, pixel_data   display pixel output
//
// Optional feature macro: VGA_FB_SWAP_EN (double buffering). It adds the
// swap_req, swap_done and front_sel ports. It offsets display addresses by
// FB_DEPTH while front_sel = 1.
module vga_fb_arbiter #(
  parameter int AW       = 20,
  parameter int DW       = 12,
  parameter int FB_DEPTH = 307200
) (
  input  logic          clk_vga,
  input  logic          rst,
  input  logic          vga_video_on,
  input  logic          first_pixel,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_ack,
  output logic          host_rvalid,
  output logic [DW-1:0] host_rdata,
  output logic          mem_re,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
`ifdef VGA_FB_SWAP_EN
  input  logic          swap_req,
  output logic          swap_done,
  output logic          front_sel,
`endif
  output logic          pixel_valid,
  output logic [DW-1:0] pixel_data
);

  // Grant tags. Host reads and writes are kept apart so that only reads
  // produce host_rvalid.
  localparam logic [1:0] TAG_NONE = 2'd0;
  localparam logic [1:0] TAG_DISP = 2'd1;
  localparam logic [1:0] TAG_HRD  = 2'd2;
  localparam logic [1:0] TAG_HWR  = 2'd3;

  logic [1:0]    w_grant;
  logic [1:0]    r_tag1;
  logic [1:0]    r_tag2;
  logic [AW-1:0] r_disp_addr;
  logic [AW-1:0] w_base;
  logic [AW-1:0] w_addr_next;
  logic [AW-1:0] w_disp_addr;

  // Grant decision. host_ack blocks a second grant of the same held request.
  always_comb begin
    w_grant = TAG_NONE;
    if (vga_video_on) begin
      w_grant = TAG_DISP;
    end else if (host_req && !host_ack) begin
      w_grant = host_we ? TAG_HWR : TAG_HRD;
    end else begin
      w_grant = TAG_NONE;
    end
  end

  // Linear display address: restarts at first_pixel, wraps by compare.
  always_comb begin
    w_base      = first_pixel ? {AW{1'b0}} : r_disp_addr;
    w_addr_next = (w_base == AW'(FB_DEPTH - 1)) ? {AW{1'b0}} : w_base + AW'(1);
  end

`ifdef VGA_FB_SWAP_EN
  logic r_front_sel;
  logic r_pending;
  logic w_front_eff;

  // The swap takes effect on the first_pixel cycle itself. The effective
  // front buffer is therefore formed combinationally, ahead of the register
  // update.
  always_comb begin
    w_front_eff = r_front_sel ^ (first_pixel & r_pending);
    w_disp_addr = w_front_eff ? (w_base + AW'(FB_DEPTH)) : w_base;
  end

  // Pending flag, front buffer select and swap_done pulse.
  // A swap_req seen on the swap cycle re-arms the flag for the next frame.
  always_ff @(posedge clk_vga) begin
    if (rst) begin
      r_front_sel <= 1'b0;
      r_pending   <= 1'b0;
      swap_done   <= 1'b0;
    end else if (first_pixel && r_pending) begin
      r_front_sel <= ~r_front_sel;
      r_pending   <= swap_req;
      swap_done   <= 1'b1;
    end else begin
      r_pending   <= r_pending | swap_req;
      swap_done   <= 1'b0;
    end
  end

  assign front_sel = r_front_sel;
`else
  assign w_disp_addr = w_base;
`endif

  // Memory command, display address counter, grant pipeline and read return.
  always_ff @(posedge clk_vga) begin
    if (rst) begin
      mem_re      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= {AW{1'b0}};
      mem_wdata   <= {DW{1'b0}};
      host_ack    <= 1'b0;
      host_rvalid <= 1'b0;
      host_rdata  <= {DW{1'b0}};
      pixel_valid <= 1'b0;
      pixel_data  <= {DW{1'b0}};
      r_disp_addr <= {AW{1'b0}};
      r_tag1      <= TAG_NONE;
      r_tag2      <= TAG_NONE;
    end else begin
      case (w_grant)
        TAG_DISP: begin
          mem_re      <= 1'b1;
          mem_we      <= 1'b0;
          mem_addr    <= w_disp_addr;
          r_disp_addr <= w_addr_next;
        end
        TAG_HRD, TAG_HWR: begin
          mem_re    <= (w_grant == TAG_HRD);
          mem_we    <= (w_grant == TAG_HWR);
          mem_addr  <= host_addr;
          mem_wdata <= host_wdata;
        end
        default: begin
          // Address and data hold, so only the strobes drop.
          mem_re <= 1'b0;
          mem_we <= 1'b0;
        end
      endcase

      host_ack <= (w_grant == TAG_HRD) || (w_grant == TAG_HWR);
      r_tag1   <= w_grant;
      r_tag2   <= r_tag1;

      // r_tag2 lines up with the cycle in which mem_rdata is valid.
      pixel_valid <= (r_tag2 == TAG_DISP);
      host_rvalid <= (r_tag2 == TAG_HRD);
      if (r_tag2 == TAG_DISP) begin
        pixel_data <= mem_rdata;
      end
      if (r_tag2 == TAG_HRD) begin
        host_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed testbench for vga_fb_arbiter. FB_DEPTH is reduced to 32 so that the
// address wrap is reachable within a short run. The memory model returns
// mem[addr] one cycle after mem_re. At reset it is loaded with data = addr.
module tb_vga_fb_arbiter;
  localparam int AW  = 20;
  localparam int DW  = 12;
  localparam int FBD = 32;

  logic          clk_vga = 1'b0;
  logic          rst;
  logic          vga_video_on;
  logic          first_pixel;
  logic          host_req;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_ack;
  logic          host_rvalid;
  logic [DW-1:0] host_rdata;
  logic          mem_re;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          pixel_valid;
  logic [DW-1:0] pixel_data;
`ifdef VGA_FB_SWAP_EN
  logic          swap_req;
  logic          swap_done;
  logic          front_sel;
`endif

  int n_pass  = 0;
  int n_total = 0;

  logic [DW-1:0] tb_mem [0:1023];

  vga_fb_arbiter #(.AW(AW), .DW(DW), .FB_DEPTH(FBD)) dut (
    .clk_vga     (clk_vga),
    .rst         (rst),
    .vga_video_on(vga_video_on),
    .first_pixel (first_pixel),
    .host_req    (host_req),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_ack    (host_ack),
    .host_rvalid (host_rvalid),
    .host_rdata  (host_rdata),
    .mem_re      (mem_re),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
`ifdef VGA_FB_SWAP_EN
    .swap_req    (swap_req),
    .swap_done   (swap_done),
    .front_sel   (front_sel),
`endif
    .pixel_valid (pixel_valid),
    .pixel_data  (pixel_data)
  );

  always #5 clk_vga = ~clk_vga;

  // Framebuffer model: synchronous single port, loaded with data = addr on reset.
  always @(posedge clk_vga) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) tb_mem[i] <= 12'(i);
      mem_rdata <= 12'd0;
    end else begin
      if (mem_re) mem_rdata <= tb_mem[mem_addr[9:0]];
      if (mem_we) tb_mem[mem_addr[9:0]] <= mem_wdata;
    end
  end

  task automatic tick();
    @(posedge clk_vga);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    rst = 1'b1; vga_video_on = 1'b0; first_pixel = 1'b0;
    host_req = 1'b0; host_we = 1'b0; host_addr = 20'd0; host_wdata = 12'd0;
`ifdef VGA_FB_SWAP_EN
    swap_req = 1'b0;
`endif
    tick(); tick();
    chk("rst_mem_re", 32'(mem_re), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_host_ack", 32'(host_ack), 32'd0);
    chk("rst_pixel_valid", 32'(pixel_valid), 32'd0);
    chk("rst_host_rvalid", 32'(host_rvalid), 32'd0);
    rst = 1'b0;

    // Display fetch of addresses 0..7, first_pixel in cycle 0.
    for (int i = 0; i < 8; i++) begin
      vga_video_on = 1'b1;
      first_pixel  = (i == 0);
      tick();
      chk("disp_re", 32'(mem_re), 32'd1);
      chk("disp_addr", 32'(mem_addr), 32'(i));
      if (i >= 2) begin
        chk("pix_valid", 32'(pixel_valid), 32'd1);
        chk("pix_data", 32'(pixel_data), 32'(i - 2));
      end else begin
        chk("pix_early", 32'(pixel_valid), 32'd0);
      end
    end
    first_pixel = 1'b0;

    // Host write waits out 5 more visible cycles.
    host_req = 1'b1; host_we = 1'b1; host_addr = 20'h100; host_wdata = 12'hABC;
    for (int i = 8; i < 13; i++) begin
      tick();
      chk("hold_ack", 32'(host_ack), 32'd0);
      chk("hold_addr", 32'(mem_addr), 32'(i));
      chk("hold_pix", 32'(pixel_data), 32'(i - 2));
    end
    vga_video_on = 1'b0;
    tick();
    chk("wr_ack", 32'(host_ack), 32'd1);
    chk("wr_we", 32'(mem_we), 32'd1);
    chk("wr_re", 32'(mem_re), 32'd0);
    chk("wr_addr", 32'(mem_addr), 32'h100);
    chk("wr_data", 32'(mem_wdata), 32'hABC);
    chk("wr_pix", 32'(pixel_data), 32'd11);
    tick();
    chk("wr_one_ack", 32'(host_ack), 32'd0);
    chk("wr_we_drop", 32'(mem_we), 32'd0);
    chk("wr_addr_hold", 32'(mem_addr), 32'h100);
    chk("wr_pix_last", 32'(pixel_data), 32'd12);
    host_req = 1'b0; host_we = 1'b0;
    tick();
    chk("pix_drain", 32'(pixel_valid), 32'd0);
    tick(); tick();

    // Host read back in blanking.
    host_req = 1'b1; host_we = 1'b0; host_addr = 20'h100;
    tick();
    chk("rd_ack", 32'(host_ack), 32'd1);
    chk("rd_re", 32'(mem_re), 32'd1);
    chk("rd_addr", 32'(mem_addr), 32'h100);
    host_req = 1'b0;
    tick();
    chk("rd_ack_once", 32'(host_ack), 32'd0);
    chk("rd_rvalid_early", 32'(host_rvalid), 32'd0);
    tick();
    chk("rd_rvalid", 32'(host_rvalid), 32'd1);
    chk("rd_rdata", 32'(host_rdata), 32'hABC);
    chk("rd_no_pix", 32'(pixel_valid), 32'd0);
    tick();
    chk("rd_rvalid_pulse", 32'(host_rvalid), 32'd0);
    tick(); tick();

    // Visible run 13..22, blanking gap, then 23..31 and wrap to 0.
    for (int k = 0; k < 10; k++) begin
      vga_video_on = 1'b1;
      tick();
      chk("run_addr", 32'(mem_addr), 32'(13 + k));
    end
    vga_video_on = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("gap_re", 32'(mem_re), 32'd0);
      chk("gap_addr_hold", 32'(mem_addr), 32'd22);
    end
    for (int k = 0; k < 10; k++) begin
      vga_video_on = 1'b1;
      tick();
      chk("wrap_addr", 32'(mem_addr), 32'((23 + k) % FBD));
    end
    vga_video_on = 1'b0;
    tick(); tick();
    chk("wrap_pix_valid", 32'(pixel_valid), 32'd1);
    chk("wrap_pix_data", 32'(pixel_data), 32'd0);
    tick(); tick();

    // Reset with a host read in flight.
    host_req = 1'b1; host_we = 1'b0; host_addr = 20'd5;
    tick();
    chk("inflight_ack", 32'(host_ack), 32'd1);
    host_req = 1'b0; rst = 1'b1;
    tick();
    chk("mrst_ack", 32'(host_ack), 32'd0);
    chk("mrst_re", 32'(mem_re), 32'd0);
    chk("mrst_addr", 32'(mem_addr), 32'd0);
    chk("mrst_rvalid", 32'(host_rvalid), 32'd0);
    chk("mrst_rdata", 32'(host_rdata), 32'd0);
    chk("mrst_pix", 32'(pixel_data), 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("mrst_no_rvalid", 32'(host_rvalid), 32'd0);
    end

`ifdef VGA_FB_SWAP_EN
    // Swap requested mid-frame takes effect at the next first_pixel.
    vga_video_on = 1'b1; first_pixel = 1'b1;
    tick();
    chk("sw_addr0", 32'(mem_addr), 32'd0);
    chk("sw_front0", 32'(front_sel), 32'd0);
    first_pixel = 1'b0; swap_req = 1'b1;
    tick();
    chk("sw_addr1", 32'(mem_addr), 32'd1);
    swap_req = 1'b0; vga_video_on = 1'b0;
    tick();
    chk("sw_front_wait", 32'(front_sel), 32'd0);
    chk("sw_done_wait", 32'(swap_done), 32'd0);
    vga_video_on = 1'b1; first_pixel = 1'b1;
    tick();
    chk("sw_front1", 32'(front_sel), 32'd1);
    chk("sw_addr_off", 32'(mem_addr), 32'(FBD));
    chk("sw_done", 32'(swap_done), 32'd1);
    first_pixel = 1'b0;
    tick();
    chk("sw_addr_next", 32'(mem_addr), 32'(FBD + 1));
    chk("sw_done_pulse", 32'(swap_done), 32'd0);
    vga_video_on = 1'b0;
    tick();
    chk("sw_front_keep", 32'(front_sel), 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
